blob_frame_sequencer: RTL



---
 rtl/blob_frame_sequencer_pkg.sv | 24 ++
 rtl/blob_frame_sequencer_seq_divider.sv | 84 ++++++++
 rtl/blob_frame_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/blob_frame_sequencer_pkg.sv
// Shared types and constants for the blob frame sequencer and its divider.
package blob_frame_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FREEZE,
    READ,
    LATCH,
    DIV_H,
    DIV_V,
    STORE,
    CLEAR,
    PUBLISH
  } state_t;

  localparam int MAX_OUT = 4;
  localparam int DIV_LAT = 32;

  // Centroids are published as 16-bit coordinates; larger quotients clamp.
  function automatic logic [15:0] sat16(input logic [DIV_LAT-1:0] q);
    return (|q[DIV_LAT-1:16]) ? 16'hFFFF : q[15:0];
  endfunction

endpackage

// File: rtl/blob_frame_sequencer_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is
// resolved on the start cycle so done lands exactly DIV_LAT cycles after start.
module seq_divider
  import blob_frame_sequencer_pkg::*;
#(
  parameter int SUM_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SUM_W-1:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               done,
  output logic [DIV_LAT-1:0] quotient
);

  localparam int STEP_W = $clog2(DIV_LAT);

  logic               running;
  logic [STEP_W-1:0]  step;
  logic [CNT_W-1:0]   rem;
  logic [CNT_W-1:0]   dsr;
  logic [DIV_LAT-1:0] quo;

  logic [CNT_W-1:0]   rem_in;
  logic [CNT_W-1:0]   dsr_in;
  logic [DIV_LAT-1:0] quo_in;
  logic [CNT_W:0]     trial;
  logic [CNT_W-1:0]   rem_next;
  logic [DIV_LAT-1:0] quo_next;

  assign quotient = quo;

  always_comb begin
    if (running) begin
      rem_in = rem;
      quo_in = quo;
      dsr_in = dsr;
    end else begin
      rem_in = '0;
      quo_in = DIV_LAT'(dividend);
      dsr_in = divisor;
    end
    trial = {rem_in, quo_in[DIV_LAT-1]};
    if (trial >= {1'b0, dsr_in}) begin
      rem_next = CNT_W'(trial - {1'b0, dsr_in});
      quo_next = {quo_in[DIV_LAT-2:0], 1'b1};
    end else begin
      rem_next = trial[CNT_W-1:0];
      quo_next = {quo_in[DIV_LAT-2:0], 1'b0};
    end
  end

  // A start while running is ignored: the running branch never reloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      done    <= 1'b0;
      step    <= '0;
      rem     <= '0;
      dsr     <= '0;
      quo     <= '0;
    end else begin
      done <= 1'b0;
      if (running || start) begin
        rem <= rem_next;
        quo <= quo_next;
        if (!running) begin
          dsr     <= divisor;
          step    <= STEP_W'(1);
          running <= 1'b1;
        end else begin
          step <= step + STEP_W'(1);
          if (step == STEP_W'(DIV_LAT - 1)) begin
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/blob_frame_sequencer.sv
// Per-frame walker over the accumulator slots: freeze, divide each valid slot
// into a centroid, clear it, and publish up to four points on frame end.
module blob_frame_sequencer
  import blob_frame_sequencer_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int MIN_PIXELS = 4,
  parameter int CNT_W      = 16,
  parameter int SUM_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VGA_VS,
  input  logic [SUM_W-1:0] SUM_H,
  input  logic [SUM_W-1:0] SUM_V,
  input  logic [CNT_W-1:0] COUNT,
  output logic [3:0]       SLOT_SEL,
  output logic             SLOT_CLR,
  output logic             ACC_FREEZE,
  output logic [15:0]      POINTS_H_0,
  output logic [15:0]      POINTS_H_1,
  output logic [15:0]      POINTS_H_2,
  output logic [15:0]      POINTS_H_3,
  output logic [15:0]      POINTS_V_0,
  output logic [15:0]      POINTS_V_1,
  output logic [15:0]      POINTS_V_2,
  output logic [15:0]      POINTS_V_3,
  output logic [2:0]       POINT_CNT,
  output logic             FRAME_DONE,
  output logic             BUSY,
  output logic             OVERRUN
);

  state_t             state;
  logic               vs_prev;
  logic               vs_rise;
  logic [3:0]         idx;
  logic [2:0]         out_idx;
  logic [SUM_W-1:0]   lat_h;
  logic [SUM_W-1:0]   lat_v;
  logic [CNT_W-1:0]   lat_cnt;
  logic [15:0]        cen_h;
  logic [15:0]        cen_v;
  logic [15:0]        shadow_h [MAX_OUT];
  logic [15:0]        shadow_v [MAX_OUT];
  logic               div_start;
  logic               div_done;
  logic [SUM_W-1:0]   div_dividend;
  logic [DIV_LAT-1:0] div_quotient;

  assign vs_rise      = VGA_VS & ~vs_prev;
  assign div_dividend = (state == DIV_V) ? lat_v : lat_h;

  seq_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) u_div (
    .clk     (CLK),
    .rst     (RST),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (lat_cnt),
    .done    (div_done),
    .quotient(div_quotient)
  );

  // Outputs are registered on the transition into the state that owns them,
  // so e.g. SLOT_CLR is high exactly during CLEAR and FRAME_DONE during PUBLISH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      vs_prev    <= 1'b0;
      idx        <= '0;
      out_idx    <= '0;
      lat_h      <= '0;
      lat_v      <= '0;
      lat_cnt    <= '0;
      cen_h      <= '0;
      cen_v      <= '0;
      div_start  <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) begin
        shadow_h[i] <= '0;
        shadow_v[i] <= '0;
      end
      SLOT_SEL   <= '0;
      SLOT_CLR   <= 1'b0;
      ACC_FREEZE <= 1'b0;
      POINTS_H_0 <= '0;
      POINTS_H_1 <= '0;
      POINTS_H_2 <= '0;
      POINTS_H_3 <= '0;
      POINTS_V_0 <= '0;
      POINTS_V_1 <= '0;
      POINTS_V_2 <= '0;
      POINTS_V_3 <= '0;
      POINT_CNT  <= '0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      vs_prev   <= VGA_VS;
      div_start <= 1'b0;
      if (vs_rise && state != IDLE) begin
        OVERRUN <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (vs_rise) begin
            ACC_FREEZE <= 1'b1;
            BUSY       <= 1'b1;
            state      <= FREEZE;
          end
        end

        FREEZE: begin
          idx      <= '0;
          out_idx  <= '0;
          SLOT_SEL <= '0;
          for (int i = 0; i < MAX_OUT; i++) begin
            shadow_h[i] <= '0;
            shadow_v[i] <= '0;
          end
          state <= READ;
        end

        READ: begin
          state <= LATCH;
        end

        LATCH: begin
          lat_h   <= SUM_H;
          lat_v   <= SUM_V;
          lat_cnt <= COUNT;
          if (COUNT < CNT_W'(MIN_PIXELS)) begin
            SLOT_CLR <= 1'b1;
            state    <= CLEAR;
          end else begin
            div_start <= 1'b1;
            state     <= DIV_H;
          end
        end

        DIV_H: begin
          if (div_done) begin
            cen_h     <= sat16(div_quotient);
            div_start <= 1'b1;
            state     <= DIV_V;
          end
        end

        DIV_V: begin
          if (div_done) begin
            cen_v <= sat16(div_quotient);
            state <= STORE;
          end
        end

        STORE: begin
          if (out_idx < 3'(MAX_OUT)) begin
            shadow_h[out_idx[1:0]] <= cen_h;
            shadow_v[out_idx[1:0]] <= cen_v;
            out_idx                <= out_idx + 3'd1;
          end
          SLOT_CLR <= 1'b1;
          state    <= CLEAR;
        end

        CLEAR: begin
          SLOT_CLR <= 1'b0;
          if (idx == 4'(NUM_SLOTS - 1)) begin
            POINTS_H_0 <= shadow_h[0];
            POINTS_H_1 <= shadow_h[1];
            POINTS_H_2 <= shadow_h[2];
            POINTS_H_3 <= shadow_h[3];
            POINTS_V_0 <= shadow_v[0];
            POINTS_V_1 <= shadow_v[1];
            POINTS_V_2 <= shadow_v[2];
            POINTS_V_3 <= shadow_v[3];
            POINT_CNT  <= out_idx;
            FRAME_DONE <= 1'b1;
            ACC_FREEZE <= 1'b0;
            SLOT_SEL   <= '0;
            state      <= PUBLISH;
          end else begin
            idx      <= idx + 4'd1;
            SLOT_SEL <= idx + 4'd1;
            state    <= READ;
          end
        end

        PUBLISH: begin
          FRAME_DONE <= 1'b0;
          BUSY       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
